// File: rtl/hive_rbus_regs.sv
// Register-bus responder: CTRL, STAT, sticky W1C EVT flags and a TX FIFO behind the rbus.
// Optional interrupt enable register and irq_o are built when HIVE_RBUS_IRQ_EN is defined.
module hive_rbus_regs #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  BASE     = 'h10,
    parameter int                 EVT_W    = 8,
    parameter int                 FIFO_D   = 4,
    parameter logic [DATA_W-1:0]  CTRL_RST = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] rbus_addr_i,
    input  logic              rbus_wr_i,
    input  logic              rbus_rd_i,
    input  logic [DATA_W-1:0] rbus_wr_data_i,
    output logic [DATA_W-1:0] rbus_rd_data_o,
    output logic [DATA_W-1:0] ctrl_o,
    input  logic [15:0]       status_i,
    input  logic [EVT_W-1:0]  evt_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              irq_o
);

    localparam int IDX_W = $clog2(FIFO_D);
    localparam int LVL_W = IDX_W + 1;

    localparam logic [ADDR_W-1:0] A_CTRL = BASE;
    localparam logic [ADDR_W-1:0] A_STAT = BASE + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_EVT  = BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_FIFO = BASE + ADDR_W'(3);

    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [EVT_W:0]    evt_q, evt_d;
    logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_D];

    logic              sel_ctrl, sel_stat, sel_evt, sel_fifo;
    logic [LVL_W-1:0]  level, free_slots;
    logic              full, empty, push_req, push, pop, overflow;
    logic [EVT_W:0]    evt_clr;
    logic [DATA_W-1:0] rd_mux;

    assign sel_ctrl = (rbus_addr_i == A_CTRL);
    assign sel_stat = (rbus_addr_i == A_STAT);
    assign sel_evt  = (rbus_addr_i == A_EVT);
    assign sel_fifo = (rbus_addr_i == A_FIFO);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level      = wr_ptr_q - rd_ptr_q;
    assign free_slots = LVL_W'(FIFO_D) - level;
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[LVL_W-1] != rd_ptr_q[LVL_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign tx_valid_o = !empty;
    assign tx_data_o  = fifo_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign pop        = tx_valid_o && tx_ready_i;
    assign push_req   = rbus_wr_i && sel_fifo;
    assign push       = push_req && (!full || pop);
    assign overflow   = push_req && full && !pop;

`ifdef HIVE_RBUS_IRQ_EN
    localparam logic [ADDR_W-1:0] A_IEN = BASE + ADDR_W'(4);
    logic           sel_ien;
    logic [EVT_W:0] ien_q, ien_d;
    logic           irq_q, irq_d;

    assign sel_ien = (rbus_addr_i == A_IEN);
    assign ien_d   = (rbus_wr_i && sel_ien) ? rbus_wr_data_i[EVT_W:0] : ien_q;
    // irq follows the stored flags, so it lags the flag update by one cycle.
    assign irq_d   = |(evt_q & ien_q);
    assign irq_o   = irq_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ien_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ien_q <= ien_d;
            irq_q <= irq_d;
        end
    end
`else
    assign irq_o = 1'b0;
`endif

    // Registers see the pre-write value here, so a read colliding with a write returns old data.
    always_comb begin
        rd_mux = '0;
        if (sel_ctrl) begin
            rd_mux = ctrl_q;
        end else if (sel_stat) begin
            rd_mux[15:0]          = status_i;
            rd_mux[LVL_W+15:16]   = level;
        end else if (sel_evt) begin
            rd_mux[EVT_W:0]       = evt_q;
        end else if (sel_fifo) begin
            rd_mux[LVL_W-1:0]     = free_slots;
`ifdef HIVE_RBUS_IRQ_EN
        end else if (sel_ien) begin
            rd_mux[EVT_W:0]       = ien_q;
`endif
        end
    end

    always_comb begin
        rd_data_d = rbus_rd_i ? rd_mux : '0;
        ctrl_d    = (rbus_wr_i && sel_ctrl) ? rbus_wr_data_i : ctrl_q;
        evt_clr   = (rbus_wr_i && sel_evt) ? rbus_wr_data_i[EVT_W:0] : '0;
        // Set is applied after clear so a same-cycle event wins over W1C.
        evt_d     = (evt_q & ~evt_clr) | {overflow, evt_i};
        wr_ptr_d  = push ? wr_ptr_q + LVL_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + LVL_W'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
            ctrl_q    <= CTRL_RST;
            evt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            ctrl_q    <= ctrl_d;
            evt_q     <= evt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[IDX_W-1:0]] <= rbus_wr_data_i;
        end
    end

    assign rbus_rd_data_o = rd_data_q;
    assign ctrl_o         = ctrl_q;

endmodule

// File: tb/tb_hive_rbus_regs.sv
// Directed bench for hive_rbus_regs: a vector table for register access plus
// hand-written FIFO, reset and interrupt sequences.
module tb_hive_rbus_regs;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  rbus_addr_i;
    logic        rbus_wr_i;
    logic        rbus_rd_i;
    logic [31:0] rbus_wr_data_i;
    logic [31:0] rbus_rd_data_o;
    logic [31:0] ctrl_o;
    logic [15:0] status_i;
    logic [7:0]  evt_i;
    logic [31:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    hive_rbus_regs dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rbus_addr_i    (rbus_addr_i),
        .rbus_wr_i      (rbus_wr_i),
        .rbus_rd_i      (rbus_rd_i),
        .rbus_wr_data_i (rbus_wr_data_i),
        .rbus_rd_data_o (rbus_rd_data_o),
        .ctrl_o         (ctrl_o),
        .status_i       (status_i),
        .evt_i          (evt_i),
        .tx_data_o      (tx_data_o),
        .tx_valid_o     (tx_valid_o),
        .tx_ready_i     (tx_ready_i),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  evt;
        logic [31:0] expRd;
        logic [31:0] expCtrl;
    } vec_t;

    vec_t vecs [16];

    // One bus cycle: drive at negedge, sample 1 time unit after the posedge, then drop the pulses.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                                 input logic [31:0] wdata, input logic [7:0] evt, input logic ready);
        @(negedge clk_i);
        rbus_wr_i      = wr;
        rbus_rd_i      = rd;
        rbus_addr_i    = addr;
        rbus_wr_data_i = wdata;
        evt_i          = evt;
        tx_ready_i     = ready;
        @(posedge clk_i);
        #1;
        rbus_wr_i = 1'b0;
        rbus_rd_i = 1'b0;
        evt_i     = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [31:0] drainExp [4];
    logic        readyPat [4];
    logic [31:0] headExp  [4];

    initial begin
        rst_n_i        = 1'b0;
        rbus_addr_i    = '0;
        rbus_wr_i      = 1'b0;
        rbus_rd_i      = 1'b0;
        rbus_wr_data_i = '0;
        status_i       = 16'hA5A5;
        evt_i          = '0;
        tx_ready_i     = 1'b0;

        vecs[0]  = '{"wr_ctrl",      1, 0, 8'h10, 32'hDEADBEEF, 8'h00, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{"rd_ctrl",      0, 1, 8'h10, 32'h0,        8'h00, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{"idle_zero",    0, 0, 8'h10, 32'h0,        8'h00, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{"rdwr_same",    1, 1, 8'h10, 32'h12345678, 8'h00, 32'hDEADBEEF, 32'h12345678};
        vecs[4]  = '{"rd_after_wr",  0, 1, 8'h10, 32'h0,        8'h00, 32'h12345678, 32'h12345678};
        vecs[5]  = '{"rd_stat",      0, 1, 8'h11, 32'h0,        8'h00, 32'h0000A5A5, 32'h12345678};
        vecs[6]  = '{"wr_stat_ign",  1, 0, 8'h11, 32'hFFFFFFFF, 8'h00, 32'h0,        32'h12345678};
        vecs[7]  = '{"rd_unmapped",  1, 1, 8'h1F, 32'hFFFFFFFF, 8'h00, 32'h0,        32'h12345678};
        vecs[8]  = '{"evt_set_clr",  1, 0, 8'h12, 32'h00000004, 8'h04, 32'h0,        32'h12345678};
        vecs[9]  = '{"rd_evt_kept",  0, 1, 8'h12, 32'h0,        8'h00, 32'h00000004, 32'h12345678};
        vecs[10] = '{"evt_w1c",      1, 0, 8'h12, 32'h00000004, 8'h00, 32'h0,        32'h12345678};
        vecs[11] = '{"rd_evt_clr",   0, 1, 8'h12, 32'h0,        8'h00, 32'h0,        32'h12345678};
        vecs[12] = '{"rd_fifo_free", 0, 1, 8'h13, 32'h0,        8'h00, 32'h00000004, 32'h12345678};
        vecs[13] = '{"rd_evt_pre",   0, 1, 8'h12, 32'h0,        8'h81, 32'h0,        32'h12345678};
        vecs[14] = '{"rd_evt_post",  0, 1, 8'h12, 32'h0,        8'h00, 32'h00000081, 32'h12345678};
        vecs[15] = '{"rd_ien_idle",  0, 1, 8'h14, 32'h0,        8'h00, 32'h0,        32'h12345678};

        #12;
        checkOutput("rst_rd_data",  rbus_rd_data_o, 32'h0);
        checkOutput("rst_ctrl",     ctrl_o,         32'h0);
        checkOutput("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        checkOutput("rst_irq",      {31'h0, irq_o},      32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].evt, 1'b0);
            checkOutput({vecs[i].name, "_rd"},   rbus_rd_data_o, vecs[i].expRd);
            checkOutput({vecs[i].name, "_ctrl"}, ctrl_o,         vecs[i].expCtrl);
        end
        applyStimulus(1, 0, 8'h12, 32'h1FF, 8'h00, 1'b0);

        // Fill the FIFO with ready held low, then overflow it.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 8'h13, 32'hA0 + 32'(i), 8'h00, 1'b0);
        end
        checkOutput("fill_valid", {31'h0, tx_valid_o}, 32'h1);
        checkOutput("fill_head",  tx_data_o, 32'hA0);
        applyStimulus(1, 0, 8'h13, 32'hA4, 8'h00, 1'b0);
        applyStimulus(0, 1, 8'h11, 32'h0, 8'h00, 1'b0);
        checkOutput("full_stat",  rbus_rd_data_o, 32'h0004A5A5);
        applyStimulus(0, 1, 8'h13, 32'h0, 8'h00, 1'b0);
        checkOutput("full_free",  rbus_rd_data_o, 32'h0);
        applyStimulus(0, 1, 8'h12, 32'h0, 8'h00, 1'b0);
        checkOutput("ovf_evt",    rbus_rd_data_o, 32'h00000100);
        checkOutput("ovf_head",   tx_data_o, 32'hA0);

        readyPat = '{1'b1, 1'b0, 1'b1, 1'b0};
        headExp  = '{32'hA1, 32'hA1, 32'hA2, 32'hA2};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 32'h0, 8'h00, readyPat[i]);
            checkOutput($sformatf("toggle_head%0d", i), tx_data_o, headExp[i]);
        end

        applyStimulus(1, 0, 8'h12, 32'h1FF, 8'h00, 1'b0);
        applyStimulus(1, 0, 8'h13, 32'hA5, 8'h00, 1'b0);
        applyStimulus(1, 0, 8'h13, 32'hA6, 8'h00, 1'b0);
        applyStimulus(1, 0, 8'h13, 32'hA7, 8'h00, 1'b1);
        checkOutput("pushpop_head", tx_data_o, 32'hA3);
        applyStimulus(0, 1, 8'h11, 32'h0, 8'h00, 1'b0);
        checkOutput("pushpop_lvl",  rbus_rd_data_o, 32'h0004A5A5);
        applyStimulus(0, 1, 8'h12, 32'h0, 8'h00, 1'b0);
        checkOutput("pushpop_evt",  rbus_rd_data_o, 32'h0);

        drainExp = '{32'hA5, 32'hA6, 32'hA7, 32'h0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 32'h0, 8'h00, 1'b1);
            if (i < 3) checkOutput($sformatf("drain_head%0d", i), tx_data_o, drainExp[i]);
        end
        checkOutput("drain_valid", {31'h0, tx_valid_o}, 32'h0);
        applyStimulus(0, 1, 8'h13, 32'h0, 8'h00, 1'b0);
        checkOutput("drain_free",  rbus_rd_data_o, 32'h00000004);

`ifdef HIVE_RBUS_IRQ_EN
        applyStimulus(1, 0, 8'h14, 32'h1, 8'h00, 1'b0);
        applyStimulus(0, 0, 8'h00, 32'h0, 8'h01, 1'b0);
        checkOutput("irq_lag",    {31'h0, irq_o}, 32'h0);
        applyStimulus(0, 0, 8'h00, 32'h0, 8'h00, 1'b0);
        checkOutput("irq_set",    {31'h0, irq_o}, 32'h1);
        applyStimulus(1, 0, 8'h12, 32'h1, 8'h00, 1'b0);
        applyStimulus(0, 0, 8'h00, 32'h0, 8'h00, 1'b0);
        checkOutput("irq_clr",    {31'h0, irq_o}, 32'h0);
`else
        applyStimulus(0, 0, 8'h00, 32'h0, 8'h01, 1'b0);
        applyStimulus(0, 0, 8'h00, 32'h0, 8'h00, 1'b0);
        checkOutput("irq_tied",   {31'h0, irq_o}, 32'h0);
        applyStimulus(1, 0, 8'h12, 32'h1FF, 8'h00, 1'b0);
`endif

        // A read is in flight when the asynchronous reset hits.
        @(negedge clk_i);
        rbus_rd_i   = 1'b1;
        rbus_addr_i = 8'h10;
        @(posedge clk_i);
        #1;
        checkOutput("pre_rst_rd", rbus_rd_data_o, 32'h12345678);
        rst_n_i = 1'b0;
        #1;
        checkOutput("async_rst_rd",   rbus_rd_data_o, 32'h0);
        checkOutput("async_rst_ctrl", ctrl_o,         32'h0);
        @(posedge clk_i);
        #1;
        checkOutput("held_rst_rd", rbus_rd_data_o, 32'h0);
        @(negedge clk_i);
        rbus_rd_i = 1'b0;
        rst_n_i   = 1'b1;
        applyStimulus(0, 1, 8'h10, 32'h0, 8'h00, 1'b0);
        checkOutput("post_rst_ctrl", rbus_rd_data_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
